// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer for the IF/ID front end: owns the PC, drives the instruction-memory
// request, handles stall/wait, branch redirect with flush bubbles, and exception halt.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET           = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES    = 1,
  // Reset value of fetch_cnt; only non-zero when exercising counter wrap.
  parameter logic [31:0] FETCH_CNT_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        inst_mem_is_valid,
  output logic        inst_mem_req,
  output logic [31:0] inst_mem_addr,
  output logic [1:0]  inst_mem_offset,
  output logic [31:0] inst_fetch_pc,
  output logic        stall_read,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

  state_t      state_r;
  logic        req_r;
  logic [31:0] addr_r;
  logic [31:0] fetch_pc_r;
  logic        stall_read_r;
  logic        halted_r;
  logic [2:0]  flush_cnt_r;
  logic [31:0] fetch_cnt_r;
  logic [31:0] bubble_cnt_r;

  // Fetch FSM with all outputs and counters registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_BOOT;
      req_r        <= 1'b0;
      addr_r       <= RESET;
      fetch_pc_r   <= RESET;
      stall_read_r <= 1'b1;
      halted_r     <= 1'b0;
      flush_cnt_r  <= 3'd0;
      fetch_cnt_r  <= FETCH_CNT_RESET;
      bubble_cnt_r <= 32'd0;
    end else begin
      // Bubbles are counted from the registered stall_read, BOOT excluded.
      if (stall_read_r && (state_r != ST_BOOT)) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end

      case (state_r)
        ST_BOOT: begin
          stall_read_r <= 1'b1;
          if (exception) begin
            state_r  <= ST_HALT;
            req_r    <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
          end
        end

        ST_FETCH, ST_FLUSH: begin
          if (exception) begin
            state_r      <= ST_HALT;
            req_r        <= 1'b0;
            stall_read_r <= 1'b1;
            halted_r     <= 1'b1;
          end else if (branch_taken) begin
            addr_r       <= branch_target;
            stall_read_r <= 1'b1;
            if (FLUSH_CYCLES > 0) begin
              flush_cnt_r <= FLUSH_LD;
              state_r     <= ST_FLUSH;
              req_r       <= 1'b0;
            end else begin
              flush_cnt_r <= 3'd0;
              state_r     <= ST_FETCH;
              req_r       <= 1'b1;
            end
          end else if (state_r == ST_FLUSH) begin
            // Leave FLUSH on the edge where the count reaches zero.
            stall_read_r <= 1'b1;
            if (flush_cnt_r <= 3'd1) begin
              flush_cnt_r <= 3'd0;
              state_r     <= ST_FETCH;
              req_r       <= 1'b1;
            end else begin
              flush_cnt_r <= flush_cnt_r - 3'd1;
            end
          end else if (stall) begin
            stall_read_r <= 1'b1;
          end else if (inst_mem_is_valid) begin
            fetch_pc_r   <= addr_r;
            addr_r       <= addr_r + 32'd4;
            stall_read_r <= 1'b0;
            fetch_cnt_r  <= fetch_cnt_r + 32'd1;
          end else begin
            stall_read_r <= 1'b1;
          end
        end

        ST_HALT: begin
          req_r        <= 1'b0;
          stall_read_r <= 1'b1;
          halted_r     <= 1'b1;
        end

        default: begin
          state_r      <= ST_BOOT;
          req_r        <= 1'b0;
          stall_read_r <= 1'b1;
          halted_r     <= 1'b0;
          flush_cnt_r  <= 3'd0;
        end
      endcase
    end
  end

  assign inst_mem_req    = req_r;
  assign inst_mem_addr   = addr_r;
  assign inst_mem_offset = addr_r[1:0];
  assign inst_fetch_pc   = fetch_pc_r;
  assign stall_read      = stall_read_r;
  assign halted          = halted_r;
  assign fetch_cnt       = fetch_cnt_r;
  assign bubble_cnt      = bubble_cnt_r;

endmodule
